// File: rtl/mem_pkg.sv
// Shared definitions for the memory client: FSM encoding, default widths, address stride.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_STRIDE = 4;

endpackage

// File: rtl/mem_client.sv
// Single-port memory client: one command in, request held until arbiter ack, read beats returned one cycle after ack.
// Optional read bursts are enabled by defining MEM_CLIENT_BURST_EN.
module mem_client
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_bank_select,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              mem_en,
  output logic              mem_we,
  output logic              burst_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  output logic [3:0]        mem_bank_select,
  input  logic              do_ack,
  input  logic [DATA_W-1:0] mem_do,
  output logic              err_spurious_ack
);

  mem_state_t        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              burst_en_q, burst_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_di_q, mem_di_d;
  logic [3:0]        mem_bank_select_q, mem_bank_select_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_last_q, rsp_last_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  load_len;

`ifdef MEM_CLIENT_BURST_EN
  assign load_len = cmd_we ? '0 : cmd_len;
`else
  logic unused_len;
  assign unused_len = ^cmd_len;
  assign load_len   = '0;
`endif

  always_comb begin
    state_d           = state_q;
    cmd_ready_d       = cmd_ready_q;
    mem_en_d          = mem_en_q;
    mem_we_d          = mem_we_q;
    mem_addr_d        = mem_addr_q;
    mem_di_d          = mem_di_q;
    mem_bank_select_d = mem_bank_select_q;
    remain_d          = remain_q;
    rsp_valid_d       = 1'b0;
    rsp_data_d        = '0;
    rsp_last_d        = 1'b0;
    // Any ack arriving while no request is outstanding is flagged and otherwise dropped.
    err_d             = err_q | (do_ack && state_q != ST_REQ);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d           = ST_REQ;
          cmd_ready_d       = 1'b0;
          mem_en_d          = 1'b1;
          mem_we_d          = cmd_we;
          mem_addr_d        = cmd_addr;
          mem_di_d          = cmd_we ? cmd_wdata : '0;
          mem_bank_select_d = cmd_bank_select;
          remain_d          = load_len;
        end
      end
      ST_REQ: begin
        if (do_ack) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_we_q ? '0 : mem_do;
          if (remain_q != '0) begin
            remain_d   = remain_q - LEN_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(ADDR_STRIDE);
          end else begin
            rsp_last_d = 1'b1;
            mem_en_d   = 1'b0;
            state_d    = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        mem_en_d    = 1'b0;
      end
    endcase

    burst_en_d = mem_en_d && (remain_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      cmd_ready_q       <= 1'b1;
      mem_en_q          <= 1'b0;
      mem_we_q          <= 1'b0;
      burst_en_q        <= 1'b0;
      mem_addr_q        <= '0;
      mem_di_q          <= '0;
      mem_bank_select_q <= '0;
      remain_q          <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_data_q        <= '0;
      rsp_last_q        <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      state_q           <= state_d;
      cmd_ready_q       <= cmd_ready_d;
      mem_en_q          <= mem_en_d;
      mem_we_q          <= mem_we_d;
      burst_en_q        <= burst_en_d;
      mem_addr_q        <= mem_addr_d;
      mem_di_q          <= mem_di_d;
      mem_bank_select_q <= mem_bank_select_d;
      remain_q          <= remain_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_data_q        <= rsp_data_d;
      rsp_last_q        <= rsp_last_d;
      err_q             <= err_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign mem_en           = mem_en_q;
  assign mem_we           = mem_we_q;
  assign burst_en         = burst_en_q;
  assign mem_addr         = mem_addr_q;
  assign mem_di           = mem_di_q;
  assign mem_bank_select  = mem_bank_select_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_last         = rsp_last_q;
  assign err_spurious_ack = err_q;

endmodule

// File: tb/tb_mem_client.sv
// Bench for mem_client: acts as core and arbiter, predicts beats from the command alone.
module tb_mem_client;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [3:0]        cmd_bank_select = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              rsp_valid, rsp_last, mem_en, mem_we, burst_en, err_spurious_ack;
  logic [DATA_W-1:0] rsp_data, mem_di;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_bank_select;
  logic              do_ack = 1'b0;
  logic [DATA_W-1:0] mem_do = '0;

  int errors = 0;
  int checks = 0;

`ifdef MEM_CLIENT_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  mem_client #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_bank_select(cmd_bank_select),
    .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .mem_en(mem_en), .mem_we(mem_we), .burst_en(burst_en),
    .mem_addr(mem_addr), .mem_di(mem_di), .mem_bank_select(mem_bank_select),
    .do_ack(do_ack), .mem_do(mem_do),
    .err_spurious_ack(err_spurious_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Number of beats a command should produce, from the command fields alone.
  function automatic int beats_of(input logic we, input logic [LEN_W-1:0] len);
    if (we || !BURST) return 1;
    return int'(len) + 1;
  endfunction

  task automatic req_fields(input int i, input int n, input logic we, input logic [ADDR_W-1:0] a0,
                            input logic [DATA_W-1:0] wd, input logic [3:0] lanes);
    logic [ADDR_W-1:0] ea;
    ea = ADDR_W'((int'(a0) + 4 * i) % (1 << ADDR_W));
    check("mem_en", mem_en, 1);
    check("mem_we", mem_we, we);
    check("mem_addr", mem_addr, ea);
    if (we) check("mem_di", mem_di, wd);
    check("mem_bank_select", mem_bank_select, lanes);
    check("burst_en", burst_en, (i < n - 1));
    check("cmd_ready_busy", cmd_ready, 0);
  endtask

  // Issue one command and serve it; dly<0 picks a random ack delay per beat.
  task automatic txn(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                     input logic [3:0] lanes, input logic [LEN_W-1:0] len, input int dly);
    int n, d;
    logic [DATA_W-1:0] rd;
    n = beats_of(we, len);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd;
    cmd_bank_select = lanes; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = ADDR_W'($urandom);
    for (int i = 0; i < n; i++) begin
      d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        req_fields(i, n, we, a, wd, lanes);
        check("rsp_idle", rsp_valid, 0);
        mem_do = $urandom;
      end
      @(negedge clk);
      req_fields(i, n, we, a, wd, lanes);
      rd = $urandom;
      do_ack = 1'b1; mem_do = rd;
      @(posedge clk); #1;
      do_ack = 1'b0; mem_do = $urandom;
      @(negedge clk);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, we ? '0 : rd);
      check("rsp_last", rsp_last, (i == n - 1));
      if (i == n - 1) begin
        check("done_mem_en", mem_en, 0);
        check("done_burst_en", burst_en, 0);
        check("done_cmd_ready", cmd_ready, 0);
      end
    end
    @(negedge clk);
    check("after_rsp", rsp_valid, 0);
    check("after_mem_en", mem_en, 0);
    check("after_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_mem_en", mem_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_err", err_spurious_ack, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk); reset = 1'b0;

    txn(1'b0, 16'h0010, '0, 4'hF, 4'd0, 2);
    txn(1'b1, 16'h0020, 32'h12345678, 4'b0011, 4'd5, 3);
    txn(1'b0, 16'hFFF8, '0, 4'hF, 4'd3, 1);
    txn(1'b0, 16'hFFFC, '0, 4'h1, 4'd1, 0);

    @(negedge clk);
    check("err_before", err_spurious_ack, 0);
    do_ack = 1'b1; mem_do = 32'hBAD0BAD0;
    @(negedge clk);
    do_ack = 1'b0;
    check("err_set", err_spurious_ack, 1);
    check("spur_no_rsp", rsp_valid, 0);
    @(negedge clk);
    check("spur_no_rsp2", rsp_valid, 0);

    for (int t = 0; t < 40; t++)
      txn(1'($urandom), ADDR_W'($urandom), $urandom, 4'($urandom), LEN_W'($urandom), -1);
    @(negedge clk);
    check("err_sticky", err_spurious_ack, 1);

    // Reset in the middle of a burst read.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0100; cmd_len = 4'd3; cmd_bank_select = 4'hF;
    @(posedge clk); #1 cmd_valid = 1'b0;
`ifdef MEM_CLIENT_BURST_EN
    @(negedge clk);
    do_ack = 1'b1; mem_do = 32'h11112222;
    @(posedge clk); #1 do_ack = 1'b0;
    @(negedge clk);
    check("mid_rsp1", rsp_valid, 1);
`endif
    @(negedge clk);
    check("mid_mem_en", mem_en, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_mem_en", mem_en, 0);
    check("ar_mem_we", mem_we, 0);
    check("ar_burst_en", burst_en, 0);
    check("ar_rsp_valid", rsp_valid, 0);
    check("ar_rsp_last", rsp_last, 0);
    check("ar_err", err_spurious_ack, 0);
    check("ar_mem_addr", mem_addr, 0);
    check("ar_mem_di", mem_di, 0);
    check("ar_rsp_data", rsp_data, 0);
    check("ar_lanes", mem_bank_select, 0);
    check("ar_cmd_ready", cmd_ready, 1);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      do_ack = (k == 1);
      @(negedge clk);
      check("post_rst_rsp", rsp_valid, 0);
      check("post_rst_mem_en", mem_en, 0);
    end
    do_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
